// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle CPU: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath control.
// Optional build macro MCFSM_MEM_WAIT_EN adds a mem_ready handshake that
// stalls FETCH, MEMRD and MEMWR until memory responds.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
`ifdef MCFSM_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       ir_write,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  state_e state_q;
  state_e state_d;

  logic mem_rdy;
  logic pc_write;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;

`ifdef MCFSM_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State register; reset from any state returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = FETCH;
    ir_write_raw  = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write_raw = mem_rdy;
        pc_write     = mem_rdy;
        alu_src_b    = 2'b01;
        state_d      = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        instr_done    = 1'b1;
      end
      MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        instr_done    = mem_rdy;
        state_d       = mem_rdy ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        instr_done    = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables are suppressed during reset so no partial writeback occurs
  assign ir_write  = ir_write_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;
  assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Build with +define+MCFSM_MEM_WAIT_EN
// to also exercise the memory wait handshake.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int vectors;
  int miscompares;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MCFSM_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of every control output except state and illegal_op
  function automatic logic [15:0] ctl();
    return {ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_src, instr_done, 1'b0};
  endfunction

  task automatic chk_ctl(input string tag, input logic [15:0] exp);
    vectors++;
    assert (ctl() === exp) else begin
      miscompares++;
      $error("FAIL %s: observed ctl %04h expected %04h", tag, ctl(), exp);
    end
  endtask

  // Control vector bit layout mirrors ctl()
  function automatic logic [15:0] mk(input logic irw, input logic pce, input logic io,
                                     input logic mw, input logic rw, input logic rd,
                                     input logic m2r, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic [1:0] ps,
                                     input logic dn);
    return {irw, pce, io, mw, rw, rd, m2r, sa, sb, op, ps, dn, 1'b0};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    mem_ready   = 1'b1;
    opcode      = 6'b000000;
    zero        = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    chk("reset_state", 8'(state), 8'd0);
    chk_ctl("reset_ctl", mk(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
    reset = 1'b0;
    #1;
    chk_ctl("fetch_after_reset", mk(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));

    // LW: 0,1,2,3,4,0
    opcode = 6'b100011;
    tick(); chk("lw_s1", 8'(state), 8'd1);
    chk_ctl("lw_decode", mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
    tick(); chk("lw_s2", 8'(state), 8'd2);
    chk_ctl("lw_memadr", mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    tick(); chk("lw_s3", 8'(state), 8'd3);
    chk_ctl("lw_memrd", mk(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    tick(); chk("lw_s4", 8'(state), 8'd4);
    chk_ctl("lw_memwb", mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1));
    tick(); chk("lw_s0", 8'(state), 8'd0);

    // SW: 0,1,2,5,0
    opcode = 6'b101011;
    tick(); chk("sw_s1", 8'(state), 8'd1);
    tick(); chk("sw_s2", 8'(state), 8'd2);
    tick(); chk("sw_s5", 8'(state), 8'd5);
    chk_ctl("sw_memwr", mk(0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,1));
    tick(); chk("sw_s0", 8'(state), 8'd0);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    tick(); chk("r_s1", 8'(state), 8'd1);
    tick(); chk("r_s6", 8'(state), 8'd6);
    chk_ctl("r_exec", mk(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
    tick(); chk("r_s7", 8'(state), 8'd7);
    chk_ctl("r_aluwb", mk(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,1));
    tick(); chk("r_s0", 8'(state), 8'd0);

    // ADDI: 0,1,9,10,0
    opcode = 6'b001000;
    tick(); chk("addi_s1", 8'(state), 8'd1);
    tick(); chk("addi_s9", 8'(state), 8'd9);
    chk_ctl("addi_ex", mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    tick(); chk("addi_s10", 8'(state), 8'd10);
    chk_ctl("addi_wb", mk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,1));
    tick(); chk("addi_s0", 8'(state), 8'd0);

    // BEQ taken
    opcode = 6'b000100;
    zero   = 1'b1;
    tick(); chk("beq1_s1", 8'(state), 8'd1);
    tick(); chk("beq1_s8", 8'(state), 8'd8);
    chk_ctl("beq_taken", mk(0,1,0,0,0,0,0,1,2'b00,2'b01,2'b01,1));
    tick(); chk("beq1_s0", 8'(state), 8'd0);

    // BEQ not taken
    zero = 1'b0;
    tick(); chk("beq0_s1", 8'(state), 8'd1);
    tick(); chk("beq0_s8", 8'(state), 8'd8);
    chk_ctl("beq_not_taken", mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1));
    tick(); chk("beq0_s0", 8'(state), 8'd0);

    // J: 0,1,11,0
    opcode = 6'b000010;
    tick(); chk("j_s1", 8'(state), 8'd1);
    tick(); chk("j_s11", 8'(state), 8'd11);
    chk_ctl("j_jump", mk(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b10,1));
    tick(); chk("j_s0", 8'(state), 8'd0);

    // Illegal opcode pulses only in DECODE
    opcode = 6'b111111;
    chk("illegal_fetch", 8'(illegal_op), 8'd0);
    tick(); chk("ill_s1", 8'(state), 8'd1);
    chk("illegal_decode", 8'(illegal_op), 8'd1);
    chk_ctl("illegal_ctl", mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
    tick(); chk("ill_s0", 8'(state), 8'd0);
    chk("illegal_after", 8'(illegal_op), 8'd0);

    // SW interrupted by reset in MEMADR
    opcode = 6'b101011;
    tick(); chk("swr_s1", 8'(state), 8'd1);
    tick(); chk("swr_s2", 8'(state), 8'd2);
    reset = 1'b1;
    #1;
    chk("swr_memw_rst", 8'(mem_write), 8'd0);
    tick(); chk("swr_s0", 8'(state), 8'd0);
    chk("swr_memw_after", 8'(mem_write), 8'd0);
    chk("swr_irw_in_reset", 8'(ir_write), 8'd0);
    reset = 1'b0;
    #1;
    chk("swr_irw_release", 8'(ir_write), 8'd1);

`ifdef MCFSM_MEM_WAIT_EN
    // FETCH stalls while memory is not ready
    opcode    = 6'b100011;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_irw", 8'(ir_write), 8'd0);
      chk("wait_pcen", 8'(pc_en), 8'd0);
      tick();
      chk("wait_state", 8'(state), 8'd0);
    end
    mem_ready = 1'b1;
    #1;
    chk("ready_irw", 8'(ir_write), 8'd1);
    tick(); chk("ready_s1", 8'(state), 8'd1);
    tick(); chk("wlw_s2", 8'(state), 8'd2);
    mem_ready = 1'b0;
    tick(); chk("wlw_s3", 8'(state), 8'd3);
    tick(); chk("wlw_s3_hold", 8'(state), 8'd3);
    mem_ready = 1'b1;
    tick(); chk("wlw_s4", 8'(state), 8'd4);
    tick(); chk("wlw_s0", 8'(state), 8'd0);
    // MEMWR holds mem_write high while waiting, instr_done only when ready
    opcode = 6'b101011;
    tick(); tick(); tick();
    chk("wsw_s5", 8'(state), 8'd5);
    mem_ready = 1'b0;
    #1;
    chk("wsw_memw_wait", 8'(mem_write), 8'd1);
    chk("wsw_done_wait", 8'(instr_done), 8'd0);
    tick(); chk("wsw_s5_hold", 8'(state), 8'd5);
    mem_ready = 1'b1;
    #1;
    chk("wsw_done_ready", 8'(instr_done), 8'd1);
    tick(); chk("wsw_s0", 8'(state), 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
